// File: rtl/ace_ccu_snoop_tracker_pkg.sv
// Shared helpers for the CCU snoop tracker and its address-match sub-module.
// Holds no state. It provides width helpers so that degenerate parameter values
// (a single initiator, or a single table entry) still give signals at least one bit wide.
package ace_ccu_snoop_tracker_pkg;

   // Width of an index over n items, never narrower than 1 bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a pointer into an n-entry circular table, never narrower than 1 bit.
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ace_ccu_cm_match.sv
// Address-match array for in-flight snoop entries.
// Each valid entry compares its stored address slice against the candidate slice. The module
// reports a per-entry hit vector, and the caller reduces that vector as needed.
// Ports:
//   valid_i    - per-entry valid bits
//   addr_i     - per-entry stored address slices
//   cmp_addr_i - candidate address slice
//   hit_o      - per-entry hit (valid && equal)
module ace_ccu_cm_match #(
   parameter int unsigned NumEntries = 4,
   parameter int unsigned Width      = 26
) (
   input  logic [NumEntries-1:0]            valid_i,
   input  logic [NumEntries-1:0][Width-1:0] addr_i,
   input  logic [Width-1:0]                 cmp_addr_i,
   output logic [NumEntries-1:0]            hit_o
);

   always_comb begin
      hit_o = '0;
      for (int unsigned i = 0; i < NumEntries; i++) begin
         hit_o[i] = valid_i[i] && (addr_i[i] == cmp_addr_i);
      end
   end

endmodule

// File: rtl/ace_ccu_snoop_tracker.sv
// In-flight snoop tracker between the CCU snoop arbiter and the AC fork.
// The tracker keeps a circular table of up to MaxTrans outstanding snoops. It stalls a new snoop
// when its cache-line slice matches an in-flight entry, or when the table is full. For each
// snoop it hands (sel, idx) to the response collector in allocation order. It frees the oldest
// issued entry on retire.
// Ports:
//   clk_i, rst_ni                       - clock, async active-low reset
//   inp_valid_i/inp_ready_o             - snoop request handshake from arbiter
//   inp_addr_i, inp_sel_i, inp_idx_i    - AC address, target outputs, originating initiator
//   oup_valid_o/oup_ready_i             - request towards AC fork (combinational path)
//   ctrl_valid_o/ctrl_ready_i           - per-snoop ctrl towards response collector
//   ctrl_sel_o, ctrl_idx_o              - sel/idx of oldest un-issued entry
//   retire_i                            - oldest issued snoop fully answered
//   usage_o                             - allocated entries
//   stall_o                             - request held back by conflict or full
module ace_ccu_snoop_tracker
   import ace_ccu_snoop_tracker_pkg::*;
#(
   parameter int unsigned NumInp      = 4,
   parameter int unsigned NumOup      = 2,
   parameter int unsigned MaxTrans    = 4,
   parameter int unsigned AddrWidth   = 32,
   parameter int unsigned CmAddrWidth = 26,
   parameter int unsigned CmAddrBase  = 6,
   parameter bit          EnConflict  = 1'b1,
   localparam int unsigned IdxW       = idx_width(NumInp),
   localparam int unsigned CntW       = $clog2(MaxTrans + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 inp_valid_i,
   output logic                 inp_ready_o,
   input  logic [AddrWidth-1:0] inp_addr_i,
   input  logic [NumOup-1:0]    inp_sel_i,
   input  logic [IdxW-1:0]      inp_idx_i,
   output logic                 oup_valid_o,
   input  logic                 oup_ready_i,
   output logic                 ctrl_valid_o,
   input  logic                 ctrl_ready_i,
   output logic [NumOup-1:0]    ctrl_sel_o,
   output logic [IdxW-1:0]      ctrl_idx_o,
   input  logic                 retire_i,
   output logic [CntW-1:0]      usage_o,
   output logic                 stall_o
);

   localparam int unsigned PtrW = ptr_width(MaxTrans);

   typedef struct packed {
      logic [NumOup-1:0] sel;
      logic [IdxW-1:0]   idx;
   } ctrl_t;

   logic [MaxTrans-1:0]                  valid_q, valid_d;
   logic [MaxTrans-1:0][CmAddrWidth-1:0] addr_q, addr_d;
   ctrl_t [MaxTrans-1:0]                 ctrl_q, ctrl_d;
   logic [PtrW-1:0]                      wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]                      ctrl_ptr_q, ctrl_ptr_d;
   logic [PtrW-1:0]                      rd_ptr_q, rd_ptr_d;
   // usage = allocated entries; pend = allocated but ctrl not yet issued
   logic [CntW-1:0]                      usage_q, usage_d;
   logic [CntW-1:0]                      pend_q, pend_d;

   logic [CmAddrWidth-1:0] cmp_addr;
   logic [MaxTrans-1:0]    hit_vec;
   logic                   hit, full, has_sel, alloc, ctrl_fire, ret_ok;
   logic [CntW-1:0]        issued;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
      return (ptr == PtrW'(MaxTrans - 1)) ? '0 : ptr + PtrW'(1);
   endfunction

   assign cmp_addr = inp_addr_i[CmAddrBase +: CmAddrWidth];

   ace_ccu_cm_match #(
      .NumEntries (MaxTrans),
      .Width      (CmAddrWidth)
   ) u_cm_match (
      .valid_i    (valid_q),
      .addr_i     (addr_q),
      .cmp_addr_i (cmp_addr),
      .hit_o      (hit_vec)
   );

   // Compare uses registered state, so a same-cycle retire of the match still stalls.
   assign hit     = EnConflict && (|hit_vec);
   assign full    = (usage_q == CntW'(MaxTrans));
   assign has_sel = |inp_sel_i;
   assign issued  = usage_q - pend_q;

   // oup_valid_o never looks at oup_ready_i. A sel==0 snoop bypasses the fork but still allocates.
   assign oup_valid_o = inp_valid_i && has_sel && !full && !hit;
   assign inp_ready_o = (has_sel ? oup_ready_i : 1'b1) && !full && !hit;
   assign stall_o     = inp_valid_i && (full || hit);

   assign alloc        = inp_valid_i && inp_ready_o;
   assign ctrl_valid_o = (pend_q != '0);
   assign ctrl_fire    = ctrl_valid_o && ctrl_ready_i;
   assign ret_ok       = retire_i && (issued != '0);

   assign ctrl_sel_o = ctrl_q[ctrl_ptr_q].sel;
   assign ctrl_idx_o = ctrl_q[ctrl_ptr_q].idx;
   assign usage_o    = usage_q;

   always_comb begin
      valid_d    = valid_q;
      addr_d     = addr_q;
      ctrl_d     = ctrl_q;
      wr_ptr_d   = wr_ptr_q;
      ctrl_ptr_d = ctrl_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      // Retire clears before allocate sets. With a non-full table they never hit the same slot.
      if (ret_ok) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = ptr_inc(rd_ptr_q);
      end
      if (alloc) begin
         valid_d[wr_ptr_q]    = 1'b1;
         addr_d[wr_ptr_q]     = cmp_addr;
         ctrl_d[wr_ptr_q].sel = inp_sel_i;
         ctrl_d[wr_ptr_q].idx = inp_idx_i;
         wr_ptr_d             = ptr_inc(wr_ptr_q);
      end
      if (ctrl_fire) begin
         ctrl_ptr_d = ptr_inc(ctrl_ptr_q);
      end
      usage_d = usage_q + CntW'(alloc) - CntW'(ret_ok);
      pend_d  = pend_q + CntW'(alloc) - CntW'(ctrl_fire);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q    <= '0;
         addr_q     <= '0;
         ctrl_q     <= '0;
         wr_ptr_q   <= '0;
         ctrl_ptr_q <= '0;
         rd_ptr_q   <= '0;
         usage_q    <= '0;
         pend_q     <= '0;
      end else begin
         valid_q    <= valid_d;
         addr_q     <= addr_d;
         ctrl_q     <= ctrl_d;
         wr_ptr_q   <= wr_ptr_d;
         ctrl_ptr_q <= ctrl_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         usage_q    <= usage_d;
         pend_q     <= pend_d;
      end
   end

   // Address bits outside the compared slice are intentionally ignored.
   logic unused_addr;
   assign unused_addr = ^inp_addr_i;

   // Retire with nothing issued-and-unretired is dropped.
   a_retire_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
      retire_i |-> (issued != '0));

endmodule
